// File: rtl/arcade_cfg_pkg.sv
// Shared types and helpers for the arcade configuration loader.
// State encoding, default ioctl indices and the mod one-hot decoder.
package arcade_cfg_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2
    } cfg_state_t;

    localparam logic [7:0] ROM_IDX_DEF = 8'd0;
    localparam logic [7:0] MOD_IDX_DEF = 8'd1;
    localparam logic [7:0] DIP_IDX_DEF = 8'd254;

    // Widest one-hot an 8-bit id can address; callers truncate to their own width.
    localparam int unsigned ONEHOT_MAX = 256;

    function automatic logic [ONEHOT_MAX-1:0] onehot_decode(input logic [7:0] id,
                                                          input int unsigned n);
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if (32'(id) < n) begin
            v[id] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/arcade_cfg_loader.sv
// Captures mod/DIP bytes from the ioctl stream into shadows, commits them atomically
// when a download ends, and holds the game core in reset around ROM/mod loads.
module arcade_cfg_loader
    import arcade_cfg_pkg::*;
#(
    parameter int unsigned          NUM_MODS      = 32,
    parameter int unsigned          DIP_BYTES     = 8,
    parameter logic [DIP_BYTES*8-1:0] DIP_RESET   = '1,
    parameter logic [7:0]           ROM_INDEX     = ROM_IDX_DEF,
    parameter logic [7:0]           MOD_INDEX     = MOD_IDX_DEF,
    parameter logic [7:0]           DIP_INDEX     = DIP_IDX_DEF,
    parameter int unsigned          SETTLE_CYCLES = 16,
    parameter int unsigned          ADDR_W        = 25
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ioctl_download,
    input  logic                   ioctl_wr,
    input  logic [7:0]             ioctl_index,
    input  logic [ADDR_W-1:0]      ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic [7:0]             mod_id,
    output logic [NUM_MODS-1:0]    mod_onehot,
    output logic                   mod_err,
    output logic [DIP_BYTES*8-1:0] dip,
    output logic                   core_reset,
    output logic                   cfg_ready
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    cfg_state_t          state_reg, state_next;
    logic [CNT_W-1:0]    settle_cnt_reg, settle_cnt_next;
    logic                commit;

    logic                dirty_mod_reg, dirty_mod_next;
    logic                dirty_dip_reg, dirty_dip_next;
    logic                rom_seen_reg, rom_seen_next;
    logic [7:0]          mod_shadow_reg;
    logic [7:0]          mod_id_reg;
    logic [NUM_MODS-1:0] mod_onehot_reg;
    logic                mod_err_reg;
    logic                core_reset_reg, core_reset_next;
    logic                cfg_ready_reg;

    logic wr_mod, wr_dip, wr_rom;

    assign wr_mod = ioctl_wr && (ioctl_index == MOD_INDEX);
    assign wr_dip = ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr < ADDR_W'(DIP_BYTES));
    assign wr_rom = ioctl_wr && (ioctl_index == ROM_INDEX);

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = '0;
        commit          = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (ioctl_download) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (!ioctl_download) begin
                    commit     = 1'b1;
                    state_next = (rom_seen_reg || dirty_mod_reg) ? ST_SETTLE : ST_RUN;
                end
            end
            ST_SETTLE: begin
                if (ioctl_download) begin
                    state_next = ST_LOAD;
                end else if (settle_cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_next = ST_RUN;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_SETTLE;
        endcase
    end

    // A write landing on the commit cycle survives as pending for the next download.
    assign dirty_mod_next  = (dirty_mod_reg && !commit) || wr_mod;
    assign dirty_dip_next  = (dirty_dip_reg && !commit) || wr_dip;
    assign rom_seen_next   = (rom_seen_reg  && !commit) || wr_rom;
    assign core_reset_next = (state_next == ST_SETTLE) ||
                             ((state_next == ST_LOAD) && rom_seen_next);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_SETTLE;
            settle_cnt_reg <= '0;
            dirty_mod_reg  <= 1'b0;
            dirty_dip_reg  <= 1'b0;
            rom_seen_reg   <= 1'b0;
            mod_shadow_reg <= 8'd0;
            mod_id_reg     <= 8'd0;
            mod_onehot_reg <= NUM_MODS'(1);
            mod_err_reg    <= 1'b0;
            core_reset_reg <= 1'b1;
            cfg_ready_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            dirty_mod_reg  <= dirty_mod_next;
            dirty_dip_reg  <= dirty_dip_next;
            rom_seen_reg   <= rom_seen_next;
            core_reset_reg <= core_reset_next;
            cfg_ready_reg  <= (state_next == ST_RUN);
            if (wr_mod) mod_shadow_reg <= ioctl_dout;
            if (commit && dirty_mod_reg) begin
                mod_id_reg     <= mod_shadow_reg;
                mod_onehot_reg <= NUM_MODS'(onehot_decode(mod_shadow_reg, NUM_MODS));
                mod_err_reg    <= (32'(mod_shadow_reg) >= NUM_MODS);
            end
        end
    end

    // One shadow/committed byte pair per DIP lane.
    genvar gi;
    generate
        for (gi = 0; gi < DIP_BYTES; gi++) begin : g_dip
            logic [7:0] shadow_reg;
            logic [7:0] byte_reg;

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_reg <= DIP_RESET[gi*8 +: 8];
                    byte_reg   <= DIP_RESET[gi*8 +: 8];
                end else begin
                    if (wr_dip && (ioctl_addr == ADDR_W'(gi))) shadow_reg <= ioctl_dout;
                    if (commit && dirty_dip_reg) byte_reg <= shadow_reg;
                end
            end

            assign dip[gi*8 +: 8] = byte_reg;
        end
    endgenerate

    assign mod_id     = mod_id_reg;
    assign mod_onehot = mod_onehot_reg;
    assign mod_err    = mod_err_reg;
    assign core_reset = core_reset_reg;
    assign cfg_ready  = cfg_ready_reg;

endmodule

// File: tb/tb_arcade_cfg_loader.sv
// Randomised scoreboard bench for arcade_cfg_loader: downloads push expected committed
// state, and a monitor compares it each time the loader returns to the ready state.
module tb_arcade_cfg_loader;

    localparam int ADDR_W = 25;
    localparam int SETTLE = 16;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              ioctl_download = 1'b0;
    logic              ioctl_wr = 1'b0;
    logic [7:0]        ioctl_index = 8'd0;
    logic [ADDR_W-1:0] ioctl_addr = '0;
    logic [7:0]        ioctl_dout = 8'd0;
    logic [7:0]        mod_id;
    logic [31:0]       mod_onehot;
    logic              mod_err;
    logic [63:0]       dip;
    logic              core_reset;
    logic              cfg_ready;

    always #5 clk_sys = ~clk_sys;

    arcade_cfg_loader dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .mod_id         (mod_id),
        .mod_onehot     (mod_onehot),
        .mod_err        (mod_err),
        .dip            (dip),
        .core_reset     (core_reset),
        .cfg_ready      (cfg_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: committed values, shadows and pending flags.
    logic [7:0] m_mod, sh_mod;
    logic [7:0] m_dip [8];
    logic [7:0] sh_dip [8];
    bit         f_mod, f_dip, f_rom;

    function automatic logic [63:0] m_dip_bus();
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = m_dip[k];
        return v;
    endfunction

    function automatic logic [31:0] m_onehot();
        return (m_mod < 8'd32) ? (32'd1 << m_mod) : 32'd0;
    endfunction

    task automatic model_reset();
        m_mod = 8'd0; sh_mod = 8'd0;
        for (int k = 0; k < 8; k++) begin m_dip[k] = 8'hFF; sh_dip[k] = 8'hFF; end
        f_mod = 0; f_dip = 0; f_rom = 0;
    endtask

    task automatic model_write(input logic [7:0] idx, input int addr, input logic [7:0] data);
        if (idx == 8'd1) begin sh_mod = data; f_mod = 1; end
        if (idx == 8'd254 && addr < 8) begin sh_dip[addr] = data; f_dip = 1; end
        if (idx == 8'd0) f_rom = 1;
    endtask

    task automatic model_commit(output bit settle, output bit rom);
        rom    = f_rom;
        settle = f_rom || f_mod;
        if (f_mod) m_mod = sh_mod;
        if (f_dip) for (int k = 0; k < 8; k++) m_dip[k] = sh_dip[k];
        f_mod = 0; f_dip = 0; f_rom = 0;
    endtask

    typedef struct {
        logic [7:0]  id;
        logic [31:0] oh;
        logic        err;
        logic [63:0] dip;
        int          run;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_expect(input int run);
        exp_t e;
        e.id = m_mod; e.oh = m_onehot(); e.err = (m_mod >= 8'd32);
        e.dip = m_dip_bus(); e.run = run;
        sb_q.push_back(e);
    endtask

    // Monitor: counts core_reset cycles while not ready, checks on each rise of cfg_ready.
    int   mon_run = 0;
    logic prev_ready = 1'b0;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            mon_run = 0;
            prev_ready = 1'b0;
        end else begin
            if (cfg_ready && !prev_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL sb_unexpected_ready: got ready with empty queue required none");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("mon_mod_id", 64'(mod_id), 64'(e.id));
                    check("mon_mod_onehot", 64'(mod_onehot), 64'(e.oh));
                    check("mon_mod_err", 64'(mod_err), 64'(e.err));
                    check("mon_dip", dip, e.dip);
                    check("mon_reset_len", 64'(mon_run), 64'(e.run));
                end
                mon_run = 0;
            end else if (!cfg_ready && core_reset) begin
                mon_run++;
            end
            prev_ready = cfg_ready;
        end
    end

    task automatic do_download(input logic [7:0] idx, input int n, input int base_addr,
                               input int base_data, input bit rnd, input int pre_run,
                               input bit push);
        bit settle, rom;
        int run;
        @(posedge clk_sys); #1;
        ioctl_download = 1'b1;
        ioctl_index = idx;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys); #1;
            ioctl_wr   = 1'b1;
            ioctl_addr = ADDR_W'(base_addr + i);
            ioctl_dout = rnd ? 8'($urandom) : 8'(base_data + i);
            model_write(idx, base_addr + i, ioctl_dout);
            @(posedge clk_sys); #1;
            ioctl_wr = 1'b0;
            check("load_mod_id", 64'(mod_id), 64'(m_mod));
            check("load_dip", dip, m_dip_bus());
            check("load_core_reset", 64'(core_reset), 64'(f_rom));
            check("load_cfg_ready", 64'(cfg_ready), 64'(0));
        end
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        model_commit(settle, rom);
        run = pre_run + (rom ? 2 * n : 0) + (settle ? SETTLE : 0);
        if (push) push_expect(run);
        @(posedge clk_sys); #1;
        check("commit_mod_id", 64'(mod_id), 64'(m_mod));
        check("commit_mod_onehot", 64'(mod_onehot), 64'(m_onehot()));
        check("commit_mod_err", 64'(mod_err), 64'(m_mod >= 8'd32));
        check("commit_dip", dip, m_dip_bus());
        check("commit_core_reset", 64'(core_reset), 64'(settle));
        check("commit_cfg_ready", 64'(cfg_ready), 64'(!settle));
        $display("download idx=%0d bytes=%0d base=%0d mod=0x%02h dip=0x%016h run=%0d",
                 idx, n, base_addr, m_mod, m_dip_bus(), run);
    endtask

    task automatic loose_write(input logic [7:0] idx, input int addr, input logic [7:0] data);
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = ADDR_W'(addr); ioctl_dout = data;
        model_write(idx, addr, data);
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        check("loose_mod_id", 64'(mod_id), 64'(m_mod));
        check("loose_dip", dip, m_dip_bus());
        $display("loose write idx=%0d addr=%0d data=0x%02h", idx, addr, data);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!cfg_ready && k < 200) begin
            @(posedge clk_sys); #1;
            k++;
        end
        n_checks++;
        if (!cfg_ready) begin
            n_errors++;
            $display("FAIL wait_ready: got cfg_ready=0 after %0d cycles required 1", k);
        end
        @(posedge clk_sys); #1;
    endtask

    task automatic reset_checks();
        check("rst_core_reset", 64'(core_reset), 64'(1));
        check("rst_cfg_ready", 64'(cfg_ready), 64'(0));
        check("rst_mod_id", 64'(mod_id), 64'(0));
        check("rst_mod_onehot", 64'(mod_onehot), 64'(1));
        check("rst_mod_err", 64'(mod_err), 64'(0));
        check("rst_dip", dip, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        push_expect(SETTLE);
        repeat (3) @(posedge clk_sys);
        #1;
        reset_checks();
        reset_n = 1'b1;
        wait_ready();

        // Directed: mod 5, DIP bank with overflow addresses, ROM, out-of-range mod.
        do_download(8'd1, 1, 0, 8'h05, 0, 0, 1);
        wait_ready();
        do_download(8'd254, 10, 0, 8'h10, 0, 0, 1);
        check("dip_directed", dip, 64'h1716151413121110);
        wait_ready();
        do_download(8'd0, 3, 0, 0, 1, 0, 1);
        wait_ready();
        do_download(8'd1, 1, 0, 8'h40, 0, 0, 1);
        check("mod_id_0x40", 64'(mod_id), 64'h40);
        wait_ready();

        // Writes outside a download stay pending until the next download ends.
        loose_write(8'd1, 0, 8'h07);
        do_download(8'd254, 2, 3, 8'hA0, 0, 0, 1);
        wait_ready();

        // Interrupt SETTLE at cycle 5 with a fresh mod download.
        do_download(8'd1, 1, 0, 8'h02, 0, 0, 0);
        repeat (4) @(posedge clk_sys);
        #1;
        check("settle_hold", 64'(core_reset), 64'(1));
        do_download(8'd1, 2, 0, 8'h0B, 0, 6, 1);
        wait_ready();

        // Reset in the middle of a DIP download discards everything.
        @(posedge clk_sys); #1;
        ioctl_download = 1'b1; ioctl_index = 8'd254;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b1; ioctl_addr = '0; ioctl_dout = 8'h33;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        @(posedge clk_sys); #1;
        reset_n = 1'b0; ioctl_download = 1'b0;
        #1;
        model_reset();
        reset_checks();
        push_expect(SETTLE);
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        $display("reset pulsed during DIP download");
        wait_ready();

        for (int it = 0; it < 30; it++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) loose_write(8'd1, 0, 8'($urandom));
                else loose_write(8'd254, $urandom_range(0, 9), 8'($urandom));
            end
            case (kind)
                0: do_download(8'd1, $urandom_range(1, 3), 0, 0, 1, 0, 1);
                1: do_download(8'd254, $urandom_range(1, 4), $urandom_range(0, 6), 0, 1, 0, 1);
                2: do_download(8'd0, $urandom_range(1, 3), 0, 0, 1, 0, 1);
                default: do_download(8'd7, $urandom_range(1, 2), 0, 0, 1, 0, 1);
            endcase
            wait_ready();
        end

        repeat (2) @(posedge clk_sys);
        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
